// File: rtl/encoder_fec_pkg.sv
// Shared definitions for the SECDED FEC path: code geometry helpers, injection modes,
// and the default-width codeword type.
package encoder_fec_pkg;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'd0,
    INJ_SINGLE = 2'd1,
    INJ_DOUBLE = 2'd2,
    INJ_RSVD   = 2'd3
  } inj_mode_t;

  // Smallest R with 2^R >= data_w + R + 1 (data_w up to 57 needs at most R=6).
  function automatic int unsigned calc_r(input int unsigned data_w);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (r == 0 && (32'd1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  // Hamming bits plus the overall parity bit at position 0.
  function automatic int unsigned calc_code_w(input int unsigned data_w);
    return data_w + calc_r(data_w) + 1;
  endfunction

  localparam int unsigned DEF_DATA_W = 11;
  localparam int unsigned DEF_CODE_W = calc_code_w(DEF_DATA_W);

  typedef logic [DEF_CODE_W-1:0] codeword_t;

endpackage

// File: rtl/secded_enc_core.sv
// Combinational extended-Hamming encoder; also used by the decoder for syndrome generation.
module secded_enc_core
  import encoder_fec_pkg::*;
#(
  parameter  int unsigned DATA_W = 11,
  localparam int unsigned R      = calc_r(DATA_W),
  localparam int unsigned CODE_W = DATA_W + R + 1
) (
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  localparam int unsigned IDX_W = $clog2(CODE_W);

  // Positions (excluding 2^j itself) whose index has bit j set.
  function automatic logic [CODE_W-1:0] parity_mask(input int unsigned j);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int unsigned p = 1; p < CODE_W; p++) begin
      if (((p >> j) & 32'd1) == 32'd1 && p != (32'd1 << j)) m[IDX_W'(p)] = 1'b1;
    end
    return m;
  endfunction

  logic [CODE_W-1:0] placed;
  logic [R-1:0]      par;
  logic [CODE_W-1:1] hi;

  // Data occupies non-power-of-two positions; position p holds data[p - 1 - clog2(p+1)].
  for (genvar p = 0; p < CODE_W; p++) begin : g_place
    if (p == 0 || (p & (p - 1)) == 0) begin : g_par_slot
      assign placed[p] = 1'b0;
    end else begin : g_data_slot
      assign placed[p] = data[p - 1 - $clog2(p + 1)];
    end
  end

  for (genvar j = 0; j < R; j++) begin : g_par
    localparam logic [CODE_W-1:0] MASK = parity_mask(j);
    assign par[j] = ^(placed & MASK);
  end

  for (genvar p = 1; p < CODE_W; p++) begin : g_hi
    if ((p & (p - 1)) == 0) begin : g_p
      assign hi[p] = par[$clog2(p)];
    end else begin : g_d
      assign hi[p] = placed[p];
    end
  end

  assign code = {hi, ^hi};

endmodule

// File: rtl/secded_stream_encoder.sv
// SECDED stream encoder: valid/ready input, buffered codeword output with backpressure,
// deterministic error injection and a wrapping accepted-word counter.
module secded_stream_encoder
  import encoder_fec_pkg::*;
#(
  parameter  int unsigned DATA_W     = 11,
  parameter  int unsigned FIFO_DEPTH = 2,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned CODE_W     = calc_code_w(DATA_W),
  localparam int unsigned POS_W      = $clog2(CODE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_data,
  input  logic              out_ready,
  input  logic [1:0]        inj_mode,
  input  logic [POS_W-1:0]  inj_pos,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef logic [CODE_W-1:0] code_t;

  code_t            enc_code;
  code_t            inj_mask;
  code_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [POS_W-1:0] nxt_pos;
  logic             push;
  logic             pop;

  secded_enc_core #(.DATA_W(DATA_W)) u_core (
    .data (in_data),
    .code (enc_code)
  );

  // Second flipped bit wraps from the top position back to bit 0.
  assign nxt_pos = (32'(inj_pos) == CODE_W - 1) ? '0 : inj_pos + POS_W'(1);

  always_comb begin
    inj_mask = '0;
    if (32'(inj_pos) < CODE_W) begin
      case (inj_mode_t'(inj_mode))
        INJ_SINGLE: inj_mask[inj_pos] = 1'b1;
        INJ_DOUBLE: begin
          inj_mask[inj_pos] = 1'b1;
          inj_mask[nxt_pos] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rst_n & en & (occ != OCC_W'(FIFO_DEPTH));
  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Output buffer, pointers, occupancy and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      word_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_code ^ inj_mask;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        word_cnt    <= word_cnt + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule
